uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Controller that schedules and drains the 16x-oversampling UART receiver.
- Generates the receiver's clock-enable from clk_50m using a runtime baud divisor.
- Services the receiver's level-held ready/ready_clr handshake and buffers received bytes in a first-word-fall-through (FWFT) FIFO.
- Presents bytes to the system through a valid/ready stream and flags overrun when the FIFO cannot accept a byte.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
DIV_W, 16, width of baud divisor
TIMEOUT_TICKS, 640, clken ticks before rx_timeout (only with UART_RX_CTRL_TIMEOUT_EN; 640 = 4 chars x 160 ticks)

Ports:
clk_50m  in  1  system clock, 50 MHz
rst_n  in  1  reset; asynchronous, active-low
enable  in  1  1 = generate rx_clken
baud_div  in  DIV_W  clk_50m cycles per oversample tick; 0 treated as 1 (e.g. 27 gives 115200 baud x16)
rx_clken  out  1  to receiver clken
rx_ready  in  1  from receiver ready (level, held until cleared)
rx_data  in  8  from receiver data
rx_ready_clr  out  1  to receiver ready_clr
m_data  out  8  FIFO head byte
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accepts m_data
fifo_count  out  $clog2(DEPTH)+1  current occupancy
overrun  out  1  sticky: a byte was dropped
overrun_clr  in  1  clears overrun

Behaviour:
Reset (rst_n low, asynchronous):
- All outputs 0, FIFO empty, divider count 0, FSM in IDLE.

Divider:
- div_cnt counts 0 .. max(baud_div,1)-1 while enable=1.
- rx_clken is a registered 1-cycle pulse, issued on the cycle after div_cnt = max(baud_div,1)-1, after which div_cnt wraps to 0.
- baud_div <= 1 gives rx_clken high every cycle.
- enable=0: div_cnt forced to 0 and rx_clken=0. The capture FSM and FIFO keep running, so a pending byte is not lost.
- A baud_div change takes effect at the next wrap; if div_cnt >= new max-1, it wraps on the next cycle.

Capture FSM (IDLE, CLEAR, WAIT_LOW):
- IDLE: on rx_ready=1, push rx_data into the FIFO, or set overrun if the push is refused. Go to CLEAR.
- CLEAR: rx_ready_clr=1 for exactly this cycle. Go to WAIT_LOW.
- WAIT_LOW: rx_ready_clr=0. Return to IDLE when rx_ready=0; otherwise stay.
- This prevents a byte still held on rx_ready from being pushed twice.
- Timing: rx_ready first seen high in cycle N gives push at the edge ending N, rx_ready_clr high in cycle N+1, back in IDLE by N+3 at the earliest.
- rx_ready_clr is high only in CLEAR.

FIFO:
- FWFT: m_data = head entry and m_valid = (count != 0), both valid the cycle after the push edge.
- Pop when m_valid & m_ready.
- Push is accepted when count < DEPTH, or when count = DEPTH and a pop happens in the same cycle. Otherwise the byte is dropped and overrun <= 1.
- Simultaneous push and pop: count unchanged, pointers both advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Pop on empty is ignored.
- m_data holds its last value while empty (don't-care to consumers).

Overrun:
- Set has priority over overrun_clr in the same cycle.

Optional Feature:
Macro UART_RX_CTRL_TIMEOUT_EN.
- Defined:
  - Adds output port rx_timeout (1 bit) and a tick counter sized for TIMEOUT_TICKS.
  - The counter increments on each rx_clken while the FIFO is non-empty.
  - It clears to 0 on any accepted push, or when the FIFO is empty.
  - rx_timeout = 1 when the counter >= TIMEOUT_TICKS; the counter saturates there.
  - Reset value 0.
- Not defined: port, counter and parameter use are absent; all other behaviour is identical.

Test Plan:
- Divider: baud_div=27, enable=1 -> rx_clken pulses every 27 cycles exactly; baud_div=0 -> rx_clken high every cycle; enable=0 -> rx_clken=0 within 1 cycle.
- Single byte: rx_data=8'hA5, rx_ready held high until rx_ready_clr is seen, m_ready=0 -> one push only; m_valid=1, m_data=A5 and fifo_count=1 the cycle after rx_ready is first seen; rx_ready_clr exactly 1 cycle.
- Fill/overrun: 9 bytes 8'h01..8'h09 with m_ready=0 (DEPTH=8) -> fifo_count=8, overrun=1, byte 09 dropped. Then drain with m_ready=1 -> 01..08 in order. overrun_clr -> overrun=0.
- Full with simultaneous pop: FIFO full with 01..08, byte 8'h10 arrives in the same cycle as a pop -> push accepted, count stays 8, overrun stays 0, next 8 reads give 02..08,10.
- Reset mid-operation: assert rst_n=0 during CLEAR with 3 bytes queued -> m_valid=0, fifo_count=0, rx_ready_clr=0, overrun=0 immediately (asynchronous); after release, a new byte 8'h3C is captured normally.
- UART_RX_CTRL_TIMEOUT_EN, TIMEOUT_TICKS=640: one byte queued, no further rx_ready -> rx_timeout=1 after the 640th rx_clken. Pop the byte -> rx_timeout=0 the next cycle.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: baud clock-enable, ready/clear capture FSM and FWFT
// byte FIFO draining a 16x-oversampling UART receiver.
// Ports: clk_50m, rst_n (async, active-low)
//   enable, baud_div       -> rx_clken (1-cycle tick every max(baud_div,1))
//   rx_ready, rx_data      <- receiver; rx_ready_clr -> receiver
//   m_data, m_valid, m_ready : FWFT byte stream; fifo_count = occupancy
//   overrun (sticky drop flag), overrun_clr
// Optional macro UART_RX_CTRL_TIMEOUT_EN adds rx_timeout: set after
// TIMEOUT_TICKS rx_clken ticks with bytes waiting and no new push.
module uart_rx_ctrl #(
   parameter int DEPTH = 8,
   parameter int DIV_W = 16
`ifdef UART_RX_CTRL_TIMEOUT_EN
   ,
   parameter int TIMEOUT_TICKS = 640
`endif
) (
   input  logic                     clk_50m,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic [DIV_W-1:0]         baud_div,
   output logic                     rx_clken,
   input  logic                     rx_ready,
   input  logic [7:0]               rx_data,
   output logic                     rx_ready_clr,
   output logic [7:0]               m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overrun,
   input  logic                     overrun_clr
`ifdef UART_RX_CTRL_TIMEOUT_EN
   ,
   output logic                     rx_timeout
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_CLEAR    = 2'd1;
   localparam logic [1:0] S_WAIT_LOW = 2'd2;

   // ---------------- divider ----------------
   logic [DIV_W-1:0] r_div_cnt;
   logic             r_clken;
   logic [DIV_W-1:0] w_div_last;

   // baud_div of 0 or 1 both mean a tick every cycle
   assign w_div_last = (baud_div <= DIV_W'(1)) ? '0
                                               : baud_div - DIV_W'(1);

   // >= so a shrinking divisor wraps on the next cycle
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         r_div_cnt <= '0;
         r_clken   <= 1'b0;
      end else if (!enable) begin
         r_div_cnt <= '0;
         r_clken   <= 1'b0;
      end else if (r_div_cnt >= w_div_last) begin
         r_div_cnt <= '0;
         r_clken   <= 1'b1;
      end else begin
         r_div_cnt <= r_div_cnt + DIV_W'(1);
         r_clken   <= 1'b0;
      end
   end

   assign rx_clken = r_clken;

   // ---------------- capture FSM ----------------
   logic [1:0] r_state;
   logic       w_push;
   logic       w_pop;
   logic       w_accept;

   assign w_push = (r_state == S_IDLE) && rx_ready;

   // WAIT_LOW holds off until the receiver drops ready, so a byte
   // still presented after the clear pulse is not taken twice
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE:     if (rx_ready) r_state <= S_CLEAR;
            S_CLEAR:    r_state <= S_WAIT_LOW;
            S_WAIT_LOW: if (!rx_ready) r_state <= S_IDLE;
            default:    r_state <= S_IDLE;
         endcase
      end
   end

   assign rx_ready_clr = (r_state == S_CLEAR);

   // ---------------- FWFT FIFO ----------------
   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_nxt;
   logic          r_overrun;

   assign w_pop    = (r_count != '0) && m_ready;
   // a full FIFO still takes the byte when the head leaves this cycle
   assign w_accept = w_push && ((r_count != L_DEPTH) || w_pop);

   always_comb begin
      w_count_nxt = r_count;
      if (w_accept && !w_pop)
         w_count_nxt = r_count + CW'(1);
      else if (!w_accept && w_pop)
         w_count_nxt = r_count - CW'(1);
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_accept) begin
         r_mem[r_wr_ptr] <= rx_data;
      end
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)    r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_nxt;
         // a fresh drop wins over a clear in the same cycle
         if (w_push && !w_accept) r_overrun <= 1'b1;
         else if (overrun_clr)    r_overrun <= 1'b0;
      end
   end

   assign m_data     = r_mem[r_rd_ptr];
   assign m_valid    = (r_count != '0);
   assign fifo_count = r_count;
   assign overrun    = r_overrun;

`ifdef UART_RX_CTRL_TIMEOUT_EN
   // ---------------- idle timeout ----------------
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [TW-1:0] L_TMO = TW'(TIMEOUT_TICKS);

   logic [TW-1:0] r_tmo_cnt;

   // cleared on the emptying edge so rx_timeout drops right after a pop
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n)
         r_tmo_cnt <= '0;
      else if (w_accept || (w_count_nxt == '0))
         r_tmo_cnt <= '0;
      else if (r_clken && (r_tmo_cnt < L_TMO))
         r_tmo_cnt <= r_tmo_cnt + TW'(1);
   end

   assign rx_timeout = (r_tmo_cnt >= L_TMO);
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed literal checks plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_uart_rx_ctrl;

   localparam int DEPTH = 8;

   logic        clk_50m = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] baud_div = 16'd27;
   logic        rx_clken;
   logic        rx_ready = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_ready_clr;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [3:0]  fifo_count;
   logic        overrun;
   logic        overrun_clr = 1'b0;
`ifdef UART_RX_CTRL_TIMEOUT_EN
   logic        rx_timeout;
`endif

   uart_rx_ctrl dut (
      .clk_50m      (clk_50m),
      .rst_n        (rst_n),
      .enable       (enable),
      .baud_div     (baud_div),
      .rx_clken     (rx_clken),
      .rx_ready     (rx_ready),
      .rx_data      (rx_data),
      .rx_ready_clr (rx_ready_clr),
      .m_data       (m_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .fifo_count   (fifo_count),
      .overrun      (overrun),
      .overrun_clr  (overrun_clr)
`ifdef UART_RX_CTRL_TIMEOUT_EN
      ,
      .rx_timeout   (rx_timeout)
`endif
   );

   always #10 clk_50m = ~clk_50m;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // One push attempt per byte the receiver raises; a byte is kept
   // while fewer than DEPTH are queued or the head leaves this cycle.
   // A tick appears after every p-th consecutive enabled cycle.
   logic [7:0] q[$];
   bit mo_ovr, mo_clken, mo_clr, prev_ready;
   bit t_pop, t_push, t_acc;
   int run, t_p;

   always @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         mo_ovr = 0; mo_clken = 0; mo_clr = 0;
         prev_ready = 0; run = 0;
      end else begin
         t_pop  = (q.size() > 0) && m_ready;
         t_push = rx_ready && !prev_ready;
         t_acc  = t_push && ((q.size() < DEPTH) || t_pop);
         if (t_pop) void'(q.pop_front());
         if (t_acc) q.push_back(rx_data);
         if (t_push && !t_acc) mo_ovr = 1;
         else if (overrun_clr) mo_ovr = 0;
         mo_clr = t_push;
         prev_ready = rx_ready;
         t_p = (baud_div == 0) ? 1 : int'(baud_div);
         if (enable) begin
            run++;
            mo_clken = ((run % t_p) == 0);
         end else begin
            run = 0;
            mo_clken = 0;
         end
      end
   end

   always @(negedge clk_50m) begin
      if (rst_n) begin
         check("m_valid", m_valid, q.size() != 0);
         check("fifo_count", fifo_count, q.size());
         if (q.size() != 0) check("m_data", m_data, q[0]);
         check("overrun", overrun, mo_ovr);
         check("rx_clken", rx_clken, mo_clken);
         check("rx_ready_clr", rx_ready_clr, mo_clr);
      end
   end

   // ---------------- receiver-side driver ----------------
   task automatic send_byte(input logic [7:0] b, input int hold);
      int n = 0;
      @(posedge clk_50m); #1;
      rx_ready = 1'b1;
      rx_data  = b;
      do begin
         @(negedge clk_50m);
         n++;
      end while (!rx_ready_clr && n < 6);
      check("clr_seen", rx_ready_clr, 1);
      repeat (hold) @(posedge clk_50m);
      @(posedge clk_50m); #1;
      rx_ready = 1'b0;
      @(posedge clk_50m);
   endtask

   task automatic drain_all();
      @(posedge clk_50m); #1;
      m_ready = 1'b1;
      repeat (DEPTH + 2) @(posedge clk_50m);
      #1 m_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "watchdog");
   end

   int n;
   bit snd_done;
   int bd_tab [6] = '{27, 0, 1, 2, 5, 3};
   int rdy_pct [6] = '{60, 15, 90, 35, 100, 5};
   logic [7:0] exp_tab [8] = '{8'h02, 8'h03, 8'h04, 8'h05,
                               8'h06, 8'h07, 8'h08, 8'h10};

   initial begin
      // reset state
      repeat (3) @(posedge clk_50m);
      #1;
      check("rst_m_valid", m_valid, 0);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_m_data", m_data, 0);
      check("rst_rx_clken", rx_clken, 0);
      check("rst_rx_ready_clr", rx_ready_clr, 0);
      check("rst_overrun", overrun, 0);
      @(negedge clk_50m) rst_n = 1'b1;

      // divider: 27 cycles between ticks
      @(posedge clk_50m); #1 enable = 1'b1;
      n = 0;
      do begin @(negedge clk_50m); n++; end
      while (!rx_clken && n < 100);
      check("clken_first", n, 28);
      for (int k = 0; k < 2; k++) begin
         n = 0;
         do begin @(negedge clk_50m); n++; end
         while (!rx_clken && n < 100);
         check("clken_period27", n, 27);
      end
      // baud_div 0: tick every cycle
      @(posedge clk_50m); #1;
      enable = 1'b0; baud_div = 16'd0;
      @(posedge clk_50m); #1 enable = 1'b1;
      @(negedge clk_50m);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_50m);
         check("clken_div0", rx_clken, 1);
      end
      // enable off: tick gone within a cycle
      @(posedge clk_50m); #1 enable = 1'b0;
      @(negedge clk_50m);
      @(negedge clk_50m);
      check("clken_disabled", rx_clken, 0);
      baud_div = 16'd3;
      @(posedge clk_50m); #1 enable = 1'b1;

      // single byte, held past the clear pulse
      @(posedge clk_50m); #1;
      rx_ready = 1'b1; rx_data = 8'hA5;
      @(negedge clk_50m);
      check("a5_not_yet", m_valid, 0);
      @(negedge clk_50m);
      check("a5_valid", m_valid, 1);
      check("a5_data", m_data, 8'hA5);
      check("a5_count", fifo_count, 1);
      check("a5_clr", rx_ready_clr, 1);
      @(negedge clk_50m);
      check("a5_clr_once", rx_ready_clr, 0);
      @(posedge clk_50m); #1 rx_ready = 1'b0;
      repeat (2) @(posedge clk_50m);
      @(negedge clk_50m);
      check("a5_no_dup", fifo_count, 1);
      drain_all();

      // fill past DEPTH, then drain in order
      for (int i = 1; i <= 9; i++) send_byte(8'(i), 0);
      @(negedge clk_50m);
      check("fill_count", fifo_count, 8);
      check("fill_overrun", overrun, 1);
      @(posedge clk_50m); #1 m_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk_50m);
         check("drain_data", m_data, 8'(i));
      end
      @(posedge clk_50m); #1 m_ready = 1'b0;
      @(negedge clk_50m);
      check("drain_empty", m_valid, 0);
      @(posedge clk_50m); #1 overrun_clr = 1'b1;
      @(posedge clk_50m); #1 overrun_clr = 1'b0;
      @(negedge clk_50m);
      check("overrun_cleared", overrun, 0);

      // full FIFO, push and pop in the same cycle
      for (int i = 1; i <= 8; i++) send_byte(8'(i), 0);
      @(posedge clk_50m); #1;
      rx_ready = 1'b1; rx_data = 8'h10; m_ready = 1'b1;
      @(posedge clk_50m); #1 m_ready = 1'b0;
      @(negedge clk_50m);
      check("fullpop_count", fifo_count, 8);
      check("fullpop_overrun", overrun, 0);
      @(posedge clk_50m); #1 rx_ready = 1'b0;
      @(posedge clk_50m); #1 m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_50m);
         check("fullpop_data", m_data, exp_tab[i]);
      end
      @(posedge clk_50m); #1 m_ready = 1'b0;

      // asynchronous reset while in CLEAR with bytes queued
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      @(posedge clk_50m); #1;
      rx_ready = 1'b1; rx_data = 8'h44;
      @(posedge clk_50m); #2;
      check("pre_rst_clr", rx_ready_clr, 1);
      rst_n = 1'b0;
      #1;
      check("arst_m_valid", m_valid, 0);
      check("arst_count", fifo_count, 0);
      check("arst_clr", rx_ready_clr, 0);
      check("arst_overrun", overrun, 0);
      rx_ready = 1'b0;
      repeat (2) @(posedge clk_50m);
      @(negedge clk_50m) rst_n = 1'b1;
      send_byte(8'h3C, 0);
      @(negedge clk_50m);
      check("post_rst_data", m_data, 8'h3C);
      check("post_rst_count", fifo_count, 1);
      drain_all();

      // randomized traffic, model compared every cycle
      for (int ph = 0; ph < 6; ph++) begin
         @(posedge clk_50m); #1;
         enable = 1'b0;
         baud_div = 16'(bd_tab[ph]);
         repeat (2) @(posedge clk_50m);
         #1 enable = 1'b1;
         snd_done = 0;
         fork
            begin
               for (int k = 0; k < 30; k++) begin
                  repeat ($urandom_range(0, 3)) @(posedge clk_50m);
                  send_byte(8'($urandom), $urandom_range(0, 2));
               end
               snd_done = 1;
            end
            begin
               while (!snd_done) begin
                  @(posedge clk_50m); #1;
                  m_ready = ($urandom_range(0, 99) < rdy_pct[ph]);
                  overrun_clr = ($urandom_range(0, 15) == 0);
               end
            end
         join
         m_ready = 1'b0;
         overrun_clr = 1'b0;
      end

`ifdef UART_RX_CTRL_TIMEOUT_EN
      drain_all();
      enable = 1'b0; baud_div = 16'd0;
      @(posedge clk_50m); #1 enable = 1'b1;
      send_byte(8'h5A, 0);
      n = 0;
      while (!rx_timeout && n < 800) begin
         @(negedge clk_50m);
         n++;
      end
      check("timeout_set", rx_timeout, 1);
      @(posedge clk_50m); #1 m_ready = 1'b1;
      @(posedge clk_50m); #1 m_ready = 1'b0;
      @(negedge clk_50m);
      check("timeout_clr", rx_timeout, 0);
`endif

      repeat (3) @(posedge clk_50m);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
